// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Purpose  : Shared definitions for the MIPS-subset control path: opcode and
//             funct encodings, ALU operation codes, PC-source and immediate
//             extension selects, the multi-cycle FSM state encoding and the
//             bundle of registered control strobes.
//  Ports    : none (package)
//  Revision : 1.0  initial multi-cycle release
// ============================================================================
package mips_ctrl_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] c_op_rtype  = 6'b000000;
   localparam logic [5:0] c_op_regimm = 6'b000001;
   localparam logic [5:0] c_op_j      = 6'b000010;
   localparam logic [5:0] c_op_jal    = 6'b000011;
   localparam logic [5:0] c_op_beq    = 6'b000100;
   localparam logic [5:0] c_op_addiu  = 6'b001001;
   localparam logic [5:0] c_op_ori    = 6'b001101;
   localparam logic [5:0] c_op_lui    = 6'b001111;
   localparam logic [5:0] c_op_lw     = 6'b100011;
   localparam logic [5:0] c_op_sw     = 6'b101011;

   // REGIMM rt selector for bgezal
   localparam logic [4:0] c_rt_bgezal = 5'b10001;

   // R-type funct codes (instr[5:0])
   localparam logic [5:0] c_fn_addu  = 6'b100001;
   localparam logic [5:0] c_fn_subu  = 6'b100011;
   localparam logic [5:0] c_fn_and   = 6'b100100;
   localparam logic [5:0] c_fn_or    = 6'b100101;
   localparam logic [5:0] c_fn_sltu  = 6'b101011;
   localparam logic [5:0] c_fn_multu = 6'b011001;
   localparam logic [5:0] c_fn_mfhi  = 6'b010000;
   localparam logic [5:0] c_fn_mflo  = 6'b010010;

   // ALU operation codes
   localparam logic [2:0] c_alu_and  = 3'b000;
   localparam logic [2:0] c_alu_or   = 3'b001;
   localparam logic [2:0] c_alu_add  = 3'b010;
   localparam logic [2:0] c_alu_sub  = 3'b110;
   localparam logic [2:0] c_alu_sltu = 3'b111;
   localparam logic [2:0] c_alu_mfhi = 3'b100;
   localparam logic [2:0] c_alu_mflo = 3'b101;

   // PC source select
   localparam logic [1:0] c_pcsrc_seq    = 2'b00;
   localparam logic [1:0] c_pcsrc_branch = 2'b01;
   localparam logic [1:0] c_pcsrc_jump   = 2'b10;

   // Immediate extension select
   localparam logic [1:0] c_imm_sign  = 2'b00;
   localparam logic [1:0] c_imm_zero  = 2'b01;
   localparam logic [1:0] c_imm_upper = 2'b10;

   // Link register
   localparam logic [4:0] c_reg_ra = 5'd31;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_MULT   = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM    = 4'd6,
      S_WB     = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_TRAP   = 4'd10
   } state_t;

   // Registered control bundle. 'fetch' and 'pcbranch' are qualifiers that the
   // top combines with mem_ready / zero to form irwrite and pcwrite.
   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       iord;
      logic       fetch;
      logic       pcwrite;
      logic       pcbranch;
      logic [1:0] pcsrc;
      logic       alusrcbimm;
      logic [1:0] immext;
      logic [2:0] alucontrol;
      logic       regwrite;
      logic [4:0] destreg;
      logic       memtoreg;
      logic       linkpc;
      logic       mulstart;
      logic       hilo_we;
   } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : mips_alu_decoder
//  Purpose  : Combinational R-type funct decode to ALU operation code, with a
//             flag telling whether the funct is one of the supported ALU ops.
//  Ports    : funct      in  6  R-type function field
//             alucontrol out 3  ALU operation code (and when not legal)
//             legal      out 1  funct is a supported ALU-class operation
//  Revision : 1.0  initial release
// ============================================================================
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       legal
);

   always_comb begin
      alucontrol = c_alu_and;
      legal      = 1'b1;
      case (funct)
         c_fn_addu: alucontrol = c_alu_add;
         c_fn_subu: alucontrol = c_alu_sub;
         c_fn_and:  alucontrol = c_alu_and;
         c_fn_or:   alucontrol = c_alu_or;
         c_fn_sltu: alucontrol = c_alu_sltu;
         c_fn_mfhi: alucontrol = c_alu_mfhi;
         c_fn_mflo: alucontrol = c_alu_mflo;
         default:   legal      = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Moore-style multi-cycle control unit for the MIPS-subset
//             datapath. Steps each instruction through fetch/decode/execute/
//             memory/writeback, waits on the memory ready handshake, sequences
//             the multi-cycle multiplier and traps on illegal opcodes or
//             memory timeouts.
//  Params   : MUL_CYCLES  multiplier latency after start (1..32)
//             MEM_TIMEOUT max wait cycles per memory access, 0 = no timeout
//  Ports    : clk, reset (async, active-high)
//             instr[31:0], zero, mem_ready              inputs
//             memread, memwrite, iord, irwrite, pcwrite,
//             pcsrc[1:0], alusrcbimm, immext[1:0],
//             alucontrol[2:0], regwrite, destreg[4:0],
//             memtoreg, linkpc, mulstart, hilo_we,
//             illegal                                   outputs
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES  = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        memread,
   output logic        memwrite,
   output logic        iord,
   output logic        irwrite,
   output logic        pcwrite,
   output logic [1:0]  pcsrc,
   output logic        alusrcbimm,
   output logic [1:0]  immext,
   output logic [2:0]  alucontrol,
   output logic        regwrite,
   output logic [4:0]  destreg,
   output logic        memtoreg,
   output logic        linkpc,
   output logic        mulstart,
   output logic        hilo_we,
   output logic        illegal
);

   localparam int c_mul_w  = $clog2(MUL_CYCLES + 1);
   localparam int c_wait_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [c_mul_w-1:0]  c_mul_last   = c_mul_w'(MUL_CYCLES);
   localparam logic [c_mul_w-1:0]  c_mul_first  = c_mul_w'(1);
   localparam logic [c_wait_w-1:0] c_wait_max   = c_wait_w'(MEM_TIMEOUT);
   localparam logic                c_timeout_en = (MEM_TIMEOUT != 0);

   state_t              r_state, w_next;
   ctrl_t               r_ctrl, w_ctrl;
   logic                r_started;
   logic                r_illegal;
   logic [c_mul_w-1:0]  r_mulcnt, w_mulcnt;
   logic [c_wait_w-1:0] r_waitcnt, w_waitcnt;

   logic [5:0] w_op, w_funct;
   logic [4:0] w_rt, w_rd;
   logic [2:0] w_funct_alu;
   logic       w_funct_legal;
   logic       w_timeout;
   logic       w_unused_fields;

   assign w_op    = instr[31:26];
   assign w_rt    = instr[20:16];
   assign w_rd    = instr[15:11];
   assign w_funct = instr[5:0];

   // rs and shamt are datapath fields; the controller never looks at them
   assign w_unused_fields = ^{instr[25:21], instr[10:6]};

   mips_alu_decoder u_alu_decoder (
      .funct      (w_funct),
      .alucontrol (w_funct_alu),
      .legal      (w_funct_legal)
   );

   // Wait budget exhausted and memory still not ready in this cycle
   assign w_timeout = c_timeout_en && (r_waitcnt == c_wait_max) && !mem_ready;

   // ------------------------------------------------------------------
   // Next-state selection
   // ------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (mem_ready)      w_next = S_DECODE;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_DECODE: begin
            w_next = S_TRAP;
            case (w_op)
               c_op_rtype: begin
                  if (w_funct == c_fn_multu) w_next = S_MULT;
                  else if (w_funct_legal)    w_next = S_EXEC_R;
               end
               c_op_lw, c_op_sw:                w_next = S_ADDR;
               c_op_addiu, c_op_ori, c_op_lui:  w_next = S_EXEC_I;
               c_op_beq:                        w_next = S_BRANCH;
               c_op_regimm: begin
                  if (w_rt == c_rt_bgezal) w_next = S_BRANCH;
               end
               c_op_j, c_op_jal:                w_next = S_JUMP;
               default:                         w_next = S_TRAP;
            endcase
         end
         S_EXEC_R, S_EXEC_I: w_next = S_WB;
         S_MULT: begin
            if (r_mulcnt == c_mul_last) w_next = S_FETCH;
         end
         S_ADDR: w_next = S_MEM;
         S_MEM: begin
            if (mem_ready)      w_next = (w_op == c_op_lw) ? S_WB : S_FETCH;
            else if (w_timeout) w_next = S_TRAP;
         end
         S_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_TRAP;
      endcase
      // First cycle out of reset only primes the FETCH strobes
      if (!r_started) w_next = S_FETCH;
   end

   // ------------------------------------------------------------------
   // Counters for the state being entered
   // ------------------------------------------------------------------
   always_comb begin
      w_waitcnt = '0;
      if ((w_next == S_FETCH) || (w_next == S_MEM)) begin
         if ((w_next != r_state) || !r_started)
            w_waitcnt = '0;
         else if (c_timeout_en && (r_waitcnt != c_wait_max))
            w_waitcnt = r_waitcnt + c_wait_w'(1);
         else
            w_waitcnt = r_waitcnt;
      end

      // Multiplier cycle number, 1-based while in MULT
      w_mulcnt = '0;
      if (w_next == S_MULT)
         w_mulcnt = (r_state == S_MULT) ? r_mulcnt + c_mul_first : c_mul_first;
   end

   // ------------------------------------------------------------------
   // Control strobes for the state being entered (registered below so that
   // they line up with the state register)
   // ------------------------------------------------------------------
   always_comb begin
      w_ctrl = '0;
      case (w_next)
         S_FETCH: begin
            w_ctrl.memread = 1'b1;
            w_ctrl.fetch   = 1'b1;
         end
         S_EXEC_R: w_ctrl.alucontrol = w_funct_alu;
         S_EXEC_I: begin
            w_ctrl.alusrcbimm = 1'b1;
            if (w_op == c_op_addiu) begin
               w_ctrl.alucontrol = c_alu_add;
               w_ctrl.immext     = c_imm_sign;
            end else if (w_op == c_op_ori) begin
               w_ctrl.alucontrol = c_alu_or;
               w_ctrl.immext     = c_imm_zero;
            end else begin
               w_ctrl.alucontrol = c_alu_or;
               w_ctrl.immext     = c_imm_upper;
            end
         end
         S_MULT: begin
            w_ctrl.mulstart = (w_mulcnt == c_mul_first);
            w_ctrl.hilo_we  = (w_mulcnt == c_mul_last);
         end
         S_ADDR: begin
            w_ctrl.alusrcbimm = 1'b1;
            w_ctrl.alucontrol = c_alu_add;
            w_ctrl.immext     = c_imm_sign;
         end
         S_MEM: begin
            w_ctrl.iord     = 1'b1;
            w_ctrl.memread  = (w_op == c_op_lw);
            w_ctrl.memwrite = (w_op == c_op_sw);
         end
         S_WB: begin
            w_ctrl.regwrite = 1'b1;
            w_ctrl.destreg  = (w_op == c_op_rtype) ? w_rd : w_rt;
            w_ctrl.memtoreg = (w_op == c_op_lw);
         end
         S_BRANCH: begin
            // Both branches take the branch-target PC only when zero is set
            w_ctrl.pcbranch = 1'b1;
            w_ctrl.pcsrc    = c_pcsrc_branch;
            if (w_op == c_op_beq) begin
               w_ctrl.alucontrol = c_alu_sub;
            end else begin
               w_ctrl.alucontrol = c_alu_sltu;
               w_ctrl.regwrite   = 1'b1;
               w_ctrl.linkpc     = 1'b1;
               w_ctrl.destreg    = c_reg_ra;
            end
         end
         S_JUMP: begin
            w_ctrl.pcwrite = 1'b1;
            w_ctrl.pcsrc   = c_pcsrc_jump;
            if (w_op == c_op_jal) begin
               w_ctrl.regwrite = 1'b1;
               w_ctrl.linkpc   = 1'b1;
               w_ctrl.destreg  = c_reg_ra;
            end
         end
         default: w_ctrl = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_ctrl    <= '0;
         r_started <= 1'b0;
         r_illegal <= 1'b0;
         r_mulcnt  <= '0;
         r_waitcnt <= '0;
      end else begin
         r_state   <= w_next;
         r_ctrl    <= w_ctrl;
         r_started <= 1'b1;
         r_illegal <= r_illegal | (w_next == S_TRAP);
         r_mulcnt  <= w_mulcnt;
         r_waitcnt <= w_waitcnt;
      end
   end

   assign memread    = r_ctrl.memread;
   assign memwrite   = r_ctrl.memwrite;
   assign iord       = r_ctrl.iord;
   // IR latch and PC+4 happen in the cycle memory delivers the word
   assign irwrite    = r_ctrl.fetch & mem_ready;
   assign pcwrite    = r_ctrl.pcwrite | (r_ctrl.fetch & mem_ready) | (r_ctrl.pcbranch & zero);
   assign pcsrc      = r_ctrl.pcsrc;
   assign alusrcbimm = r_ctrl.alusrcbimm;
   assign immext     = r_ctrl.immext;
   assign alucontrol = r_ctrl.alucontrol;
   assign regwrite   = r_ctrl.regwrite;
   assign destreg    = r_ctrl.destreg;
   assign memtoreg   = r_ctrl.memtoreg;
   assign linkpc     = r_ctrl.linkpc;
   assign mulstart   = r_ctrl.mulstart;
   assign hilo_we    = r_ctrl.hilo_we;
   assign illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_controller
//  Purpose  : Directed self-checking bench for multicycle_controller
//             (MUL_CYCLES=4, MEM_TIMEOUT=3). Inputs change on the falling
//             edge; all outputs are sampled 1 time unit later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        memread, memwrite, iord, irwrite, pcwrite;
   logic [1:0]  pcsrc;
   logic        alusrcbimm;
   logic [1:0]  immext;
   logic [2:0]  alucontrol;
   logic        regwrite;
   logic [4:0]  destreg;
   logic        memtoreg, linkpc, mulstart, hilo_we, illegal;

   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       iord;
      logic       irwrite;
      logic       pcwrite;
      logic [1:0] pcsrc;
      logic       alusrcbimm;
      logic [1:0] immext;
      logic [2:0] alucontrol;
      logic       regwrite;
      logic [4:0] destreg;
      logic       memtoreg;
      logic       linkpc;
      logic       mulstart;
      logic       hilo_we;
      logic       illegal;
   } ov_t;

   ov_t act;
   int  checks   = 0;
   int  failures = 0;

   assign act = {memread, memwrite, iord, irwrite, pcwrite, pcsrc, alusrcbimm, immext,
                 alucontrol, regwrite, destreg, memtoreg, linkpc, mulstart, hilo_we, illegal};

   always #5 clk = ~clk;

   multicycle_controller #(
      .MUL_CYCLES  (4),
      .MEM_TIMEOUT (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .memread    (memread),
      .memwrite   (memwrite),
      .iord       (iord),
      .irwrite    (irwrite),
      .pcwrite    (pcwrite),
      .pcsrc      (pcsrc),
      .alusrcbimm (alusrcbimm),
      .immext     (immext),
      .alucontrol (alucontrol),
      .regwrite   (regwrite),
      .destreg    (destreg),
      .memtoreg   (memtoreg),
      .linkpc     (linkpc),
      .mulstart   (mulstart),
      .hilo_we    (hilo_we),
      .illegal    (illegal)
   );

   // Advance one cycle: drive inputs on the falling edge, then settle
   task automatic cyc(input logic rdy, input logic z);
      @(negedge clk);
      mem_ready = rdy;
      zero      = z;
      #1;
   endtask

   // Pulse reset; returns on a falling edge with reset just released
   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      mem_ready = 1'b0;
      zero      = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      ov_t e;
      reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; instr = 32'h00221821;
      repeat (2) @(negedge clk);
      #1;
      e = '0;
      checks++; if (act !== e) begin failures++; $display("FAIL reset_hold act=%h exp=%h", act, e); end
      @(negedge clk); reset = 1'b0; #1;
      e = '0;
      checks++; if (act !== e) begin failures++; $display("FAIL reset_release act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL reset_first_fetch act=%h exp=%h", act, e); end
   endtask

   task automatic test_addu();
      ov_t e;
      do_reset();
      instr = 32'h00221821;   // addu $3,$1,$2
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL addu_fetch act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0;
      checks++; if (act !== e) begin failures++; $display("FAIL addu_decode act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.alucontrol = 3'b010;
      checks++; if (act !== e) begin failures++; $display("FAIL addu_exec act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.regwrite = 1'b1; e.destreg = 5'd3;
      checks++; if (act !== e) begin failures++; $display("FAIL addu_wb act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL addu_refetch act=%h exp=%h", act, e); end
   endtask

   // Continues straight from the FETCH cycle test_addu leaves off in
   task automatic test_back_to_back();
      ov_t e;
      instr = 32'hAC250008;   // sw $5,8($1)
      cyc(1'b1, 1'b0);
      e = '0;
      checks++; if (act !== e) begin failures++; $display("FAIL b2b_sw_decode act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.alusrcbimm = 1'b1; e.alucontrol = 3'b010;
      checks++; if (act !== e) begin failures++; $display("FAIL b2b_sw_addr act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.memwrite = 1'b1; e.iord = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL b2b_sw_mem act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL b2b_sw_fetch act=%h exp=%h", act, e); end
   endtask

   task automatic test_lw_wait();
      ov_t e;
      do_reset();
      instr = 32'h8C250004;   // lw $5,4($1)
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL lw_fetch act=%h exp=%h", act, e); end
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      e = '0; e.alusrcbimm = 1'b1; e.alucontrol = 3'b010; e.immext = 2'b00;
      checks++; if (act !== e) begin failures++; $display("FAIL lw_addr act=%h exp=%h", act, e); end
      for (int i = 0; i < 3; i++) begin
         cyc((i == 2), 1'b0);
         e = '0; e.memread = 1'b1; e.iord = 1'b1;
         checks++; if (act !== e) begin failures++; $display("FAIL lw_mem_cycle%0d act=%h exp=%h", i, act, e); end
      end
      cyc(1'b0, 1'b0);
      e = '0; e.regwrite = 1'b1; e.destreg = 5'd5; e.memtoreg = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL lw_wb act=%h exp=%h", act, e); end
      cyc(1'b0, 1'b0);
      e = '0; e.memread = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL lw_cycle8_fetch act=%h exp=%h", act, e); end
   endtask

   task automatic test_branch();
      ov_t e;
      do_reset();
      instr = 32'h10220010;   // beq $1,$2,16
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      e = '0; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
      checks++; if (act !== e) begin failures++; $display("FAIL beq_not_taken act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL beq_refetch act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      e = '0; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL beq_taken act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      instr = 32'h04310010;   // bgezal $1,16
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      e = '0; e.alucontrol = 3'b111; e.pcsrc = 2'b01; e.regwrite = 1'b1;
      e.linkpc = 1'b1; e.destreg = 5'd31;
      checks++; if (act !== e) begin failures++; $display("FAIL bgezal_link act=%h exp=%h", act, e); end
   endtask

   task automatic test_itype_jump();
      ov_t e;
      do_reset();
      instr = 32'h3C041234;   // lui $4,0x1234
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      e = '0; e.alusrcbimm = 1'b1; e.alucontrol = 3'b001; e.immext = 2'b10;
      checks++; if (act !== e) begin failures++; $display("FAIL lui_exec act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.regwrite = 1'b1; e.destreg = 5'd4;
      checks++; if (act !== e) begin failures++; $display("FAIL lui_wb act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      instr = 32'h342600FF;   // ori $6,$1,0xff
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      e = '0; e.alusrcbimm = 1'b1; e.alucontrol = 3'b001; e.immext = 2'b01;
      checks++; if (act !== e) begin failures++; $display("FAIL ori_exec act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.regwrite = 1'b1; e.destreg = 5'd6;
      checks++; if (act !== e) begin failures++; $display("FAIL ori_wb act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      instr = 32'h0C000010;   // jal 0x40
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      e = '0; e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.regwrite = 1'b1; e.linkpc = 1'b1;
      e.destreg = 5'd31;
      checks++; if (act !== e) begin failures++; $display("FAIL jal_jump act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL jal_refetch act=%h exp=%h", act, e); end
   endtask

   task automatic test_multu();
      ov_t e;
      do_reset();
      instr = 32'h00220019;   // multu $1,$2
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, 1'b0);
         e = '0; e.mulstart = (i == 1); e.hilo_we = (i == 4);
         checks++; if (act !== e) begin failures++; $display("FAIL multu_cycle%0d act=%h exp=%h", i, act, e); end
      end
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL multu_refetch act=%h exp=%h", act, e); end
   endtask

   task automatic test_illegal();
      ov_t e;
      do_reset();
      instr = 32'hFC000000;   // opcode 0x3F
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      e = '0;
      checks++; if (act !== e) begin failures++; $display("FAIL illegal_decode act=%h exp=%h", act, e); end
      for (int i = 0; i < 20; i++) begin
         cyc(i[0], i[1]);
         e = '0; e.illegal = 1'b1;
         checks++; if (act !== e) begin failures++; $display("FAIL illegal_trap_cycle%0d act=%h exp=%h", i, act, e); end
      end
      @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
      e = '0;
      checks++; if (act !== e) begin failures++; $display("FAIL illegal_reset_clear act=%h exp=%h", act, e); end
      @(negedge clk); reset = 1'b0;
      cyc(1'b0, 1'b0);
      e = '0; e.memread = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL illegal_resume_fetch act=%h exp=%h", act, e); end
   endtask

   task automatic test_timeout();
      ov_t e;
      do_reset();
      instr = 32'h00221821;
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b0);
         e = '0; e.memread = 1'b1;
         checks++; if (act !== e) begin failures++; $display("FAIL timeout_fetch_cycle%0d act=%h exp=%h", i, act, e); end
      end
      cyc(1'b0, 1'b0);
      e = '0; e.illegal = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL timeout_trap act=%h exp=%h", act, e); end
   endtask

   task automatic test_reset_mid_mult();
      ov_t e;
      do_reset();
      instr = 32'h00220019;
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      e = '0; e.mulstart = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL abort_mult_start act=%h exp=%h", act, e); end
      cyc(1'b1, 1'b0);
      #2 reset = 1'b1;
      #1;
      e = '0;
      checks++; if (act !== e) begin failures++; $display("FAIL abort_immediate act=%h exp=%h", act, e); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++; if (act !== e) begin failures++; $display("FAIL abort_hold_cycle%0d act=%h exp=%h", i, act, e); end
      end
      @(negedge clk); reset = 1'b0;
      cyc(1'b1, 1'b0);
      e = '0; e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
      checks++; if (act !== e) begin failures++; $display("FAIL abort_refetch act=%h exp=%h", act, e); end
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      zero      = 1'b0;
      instr     = '0;
      test_reset();
      test_addu();
      test_back_to_back();
      test_lw_wait();
      test_branch();
      test_itype_jump();
      test_multu();
      test_illegal();
      test_timeout();
      test_reset_mid_mult();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
